i2c_xfer_seq: RTL and testbench
===============================

# i2c_xfer_seq

Transaction sequencer between the APB register block and `i2c_master`. It turns a single `go` request (device address, write length, read length) into the `i2c_master` command and data stream handshakes: an optional write burst followed by an optional repeated-start read. It buffers write bytes in a small FIFO and reports completion and NACK status back to the register file.

## Interface
Parameters:
- `TX_DEPTH`, 4: write FIFO depth in bytes; must be a power of two, at least 2.
- `TIMEOUT_CYCLES`, 65535: watchdog limit, 16-bit. Used only when the timeout feature is compiled in.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `go` in 1: start pulse. Ignored while `busy`=1.
- `dev_addr` in 7: target address. Latched on an accepted `go`.
- `wr_len` in 8: write byte count. Latched on an accepted `go`.
- `rd_len` in 8: read byte count. Latched on an accepted `go`.
- `busy` out 1: a transaction is in progress.
- `done` out 1: one-cycle completion pulse.
- `nack` out 1: sticky missed-ACK flag for the current or last transaction. Cleared on an accepted `go`.
- `timeout` out 1: sticky watchdog flag. Cleared on an accepted `go`. Tied to 0 when the feature is compiled out.
- `wr_data` in 8, `wr_valid` in 1, `wr_ready` out 1: push port into the TX FIFO.
- `rd_data` out 8, `rd_valid` out 1, `rd_ready` in 1: read byte output.
- `cmd_address` out 7, `cmd_start` out 1, `cmd_read` out 1, `cmd_write` out 1, `cmd_write_multiple` out 1, `cmd_stop` out 1, `cmd_valid` out 1, `cmd_ready` in 1: command stream to `i2c_master`.
- `tx_tdata` out 8, `tx_tvalid` out 1, `tx_tready` in 1, `tx_tlast` out 1: write data stream to `i2c_master`.
- `rx_tdata` in 8, `rx_tvalid` in 1, `rx_tready` out 1, `rx_tlast` in 1: read data stream from `i2c_master`. `rx_tlast` is unused.
- `master_busy` in 1, `missed_ack` in 1: status from `i2c_master`.

## Operation
States: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DRAIN, FINISH.
- **IDLE.** On `go`, latch `dev_addr`, `wr_len` and `rd_len`, clear `nack` and `timeout`, set `busy`. Next state:
  - `wr_len`≠0 → WR_CMD.
  - `wr_len`=0 and `rd_len`≠0 → RD_CMD.
  - both 0 → FINISH.
- **WR_CMD.** Present `cmd_start`=1, `cmd_write_multiple`=1, `cmd_stop`=(`rd_len`==0), all other command bits 0. Hold until `cmd_valid`&&`cmd_ready`, then → WR_DATA.
- **WR_DATA.** Stream FIFO bytes to `tx_*`.
  - `tx_tvalid` = FIFO not empty.
  - `tx_tlast` = 1 on byte number `wr_len`.
  - Count `tx_tvalid`&&`tx_tready` beats. After beat `wr_len`: → RD_CMD if `rd_len`≠0, else → FINISH.
  - If the FIFO underruns, `tx_tvalid` stays low. Never inject filler bytes.
- **RD_CMD.** Issue `rd_len` single-byte commands, one per `cmd_ready` handshake, back-to-back.
  - Every read command: `cmd_read`=1.
  - `cmd_start`=1 on the first read command only.
  - `cmd_stop`=1 on the last read command only.
  - After the last command is accepted → RD_DRAIN.
- **Read data path.** Pass-through in all states: `rd_data`=`rx_tdata`, `rd_valid`=`rx_tvalid`, `rx_tready`=`rd_ready`.
  - Count `rx_tvalid`&&`rx_tready` beats. The count runs concurrently with RD_CMD.
- **RD_DRAIN.** Wait until the rx beat count equals `rd_len`, then → FINISH.
- **FINISH.** Wait for `master_busy`=0. Then pulse `done` for one cycle, clear `busy`, → IDLE.
- **NACK.** A `missed_ack` pulse in any non-IDLE state sets `nack`. The sequence continues unchanged; `i2c_master` owns bus recovery.
- **TX FIFO.**
  - `wr_ready` = FIFO not full, independent of state, so software may preload bytes before `go`.
  - A simultaneous push and pop when full is not allowed. `wr_ready`=0 blocks the push.
  - Simultaneous push and pop when neither full nor empty leaves the occupancy unchanged.
  - Pointers wrap modulo `TX_DEPTH`.
- **Widths.** Byte counters are 8 bits; the maximum length is 255.
- **Reset.** Effective on the next edge, including mid-transaction. State → IDLE; FIFO and counters cleared. All outputs return to 0: `busy`, `done`, `nack`, `timeout`, `cmd_*`, `tx_*` and `wr_ready`. `wr_ready` rises the cycle after `rst` deasserts.

## Timing
- `cmd_valid` is registered and rises the cycle after `go` is accepted.
- Command fields are stable while `cmd_valid`=1 and `cmd_ready`=0. The same holds for `tx_*` while `tx_tvalid`=1 and `tx_tready`=0.
- After a read-command handshake, the next read command is valid in the following cycle, giving one command per cycle at full throughput.
- TX FIFO: a push in cycle N makes the byte visible on `tx_tdata` in cycle N+1. The FIFO is first-word-fall-through.
- `done` is asserted one cycle after FINISH samples `master_busy`=0.
- `busy` falls in the same cycle `done` is asserted.
- A `go` coincident with `done` is ignored.

## Configuration
- **Macro:** `I2C_XFER_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit watchdog resets on every state change and every handshake. It increments while `busy`=1.
  - When it reaches `TIMEOUT_CYCLES`: set `timeout`, drop `cmd_valid` and `tx_tvalid`, flush the FIFO, → FINISH.
  - FINISH still waits for `master_busy`=0.
- **Undefined:** no watchdog, and `timeout` is the constant 0.

## Test plan
1. Reset mid-WR_DATA → next cycle: `busy`=0, `cmd_valid`=0, `tx_tvalid`=0, FIFO empty, `wr_ready`=1 one cycle after `rst` falls.
2. Preload bytes 0xA1, 0xB2, 0xC3; `go` with addr 0x50, `wr_len`=3, `rd_len`=0 → one command (start=1, write_multiple=1, stop=1, address=0x50); three tx beats with `tx_tlast` only on 0xC3; `done` pulse; `nack`=0.
3. `go` with addr 0x68, `wr_len`=1, `rd_len`=2, `cmd_ready` held at 1 → commands in order:
   - write_multiple, stop=0;
   - read, start=1, stop=0;
   - read, start=0, stop=1.

   Then two rx bytes 0x11, 0x22 delivered on `rd_data`, then `done`.
4. `wr_len`=0 and `rd_len`=0 → no command is issued; `done` is asserted once `master_busy`=0.
5. `missed_ack` pulse during WR_DATA → `nack`=1 through `done`; the next `go` clears it.
6. With `I2C_XFER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: `go` with `wr_len`=2 and an empty FIFO → `timeout`=1 after 100 stalled cycles, then `done`.

Source files
------------

// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq
// Transaction sequencer between the APB register block and i2c_master. A single
// accepted `go` becomes an optional multi-byte write burst followed by an
// optional repeated-start read of single-byte commands. Write bytes are held in
// a small first-word-fall-through FIFO that software may fill before `go`.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   go, dev_addr, wr_len, rd_len  transaction request (latched on accepted go)
//   busy, done, nack, timeout     status to the register file
//   wr_data/wr_valid/wr_ready     push port into the TX FIFO
//   rd_data/rd_valid/rd_ready     read bytes (pass-through of rx_*)
//   cmd_*                         command stream to i2c_master
//   tx_*                          write data stream to i2c_master
//   rx_*                          read data stream from i2c_master (rx_tlast unused)
//   master_busy, missed_ack       status from i2c_master
//
// Optional feature: define I2C_XFER_TIMEOUT_EN to compile in a 16-bit watchdog
// that aborts a stalled transaction after TIMEOUT_CYCLES idle cycles.
module i2c_xfer_seq #(
  parameter int TX_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [6:0] dev_addr,
  input  logic [7:0] wr_len,
  input  logic [7:0] rd_len,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       timeout,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [6:0] cmd_address,
  output logic       cmd_start,
  output logic       cmd_read,
  output logic       cmd_write,
  output logic       cmd_write_multiple,
  output logic       cmd_stop,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] tx_tdata,
  output logic       tx_tvalid,
  input  logic       tx_tready,
  output logic       tx_tlast,
  input  logic [7:0] rx_tdata,
  input  logic       rx_tvalid,
  output logic       rx_tready,
  input  logic       rx_tlast,
  input  logic       master_busy,
  input  logic       missed_ack
);

  localparam int            AW       = $clog2(TX_DEPTH);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(TX_DEPTH);
  localparam logic [15:0]   TO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_CMD   = 3'd1,
    S_WR_DATA  = 3'd2,
    S_RD_CMD   = 3'd3,
    S_RD_DRAIN = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  state_t      state_r, state_s, state_fsm_s;
  logic [6:0]  addr_r;
  logic [7:0]  wr_len_r, rd_len_r, rd_len_nx_s;
  logic [7:0]  tx_cnt_r, rd_cmd_cnt_r, rd_cmd_cnt_s, rx_cnt_r;
  logic        busy_r, done_r, nack_r, wr_ready_r;
  logic        cmd_valid_r, cmd_start_r, cmd_read_r, cmd_wm_r, cmd_stop_r;
  logic        cmd_valid_s, cmd_start_s, cmd_read_s, cmd_wm_s, cmd_stop_s;
  logic        accept_s, cmd_hs_s, pop_s, push_s, rx_beat_s, wd_fire_s, unused_s;
  logic [7:0]  mem_r [TX_DEPTH];
  logic [AW-1:0] wptr_r, rptr_r, wptr_s, rptr_s;
  logic [AW:0] count_r, count_s;

  assign cmd_hs_s  = cmd_valid_r && cmd_ready;
  assign tx_tvalid = (state_r == S_WR_DATA) && (count_r != '0);
  assign pop_s     = tx_tvalid && tx_tready;
  assign push_s    = wr_valid && wr_ready_r;
  assign rx_beat_s = rx_tvalid && rd_ready;

  // Next-state decode; the watchdog abort overrides the normal sequence.
  always_comb begin
    state_fsm_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        // done_r is high in the first IDLE cycle, so a coincident go is dropped
        if (go && !done_r) begin
          accept_s = 1'b1;
          if (wr_len != 8'd0) state_fsm_s = S_WR_CMD;
          else if (rd_len != 8'd0) state_fsm_s = S_RD_CMD;
          else state_fsm_s = S_FINISH;
        end else begin
          state_fsm_s = S_IDLE;
        end
      end
      S_WR_CMD: begin
        if (cmd_hs_s) state_fsm_s = S_WR_DATA;
        else state_fsm_s = S_WR_CMD;
      end
      S_WR_DATA: begin
        if (pop_s && (tx_cnt_r == wr_len_r - 8'd1))
          state_fsm_s = (rd_len_r != 8'd0) ? S_RD_CMD : S_FINISH;
        else
          state_fsm_s = S_WR_DATA;
      end
      S_RD_CMD: begin
        if (cmd_hs_s && (rd_cmd_cnt_r == rd_len_r - 8'd1)) state_fsm_s = S_RD_DRAIN;
        else state_fsm_s = S_RD_CMD;
      end
      S_RD_DRAIN: begin
        if (rx_cnt_r == rd_len_r) state_fsm_s = S_FINISH;
        else state_fsm_s = S_RD_DRAIN;
      end
      S_FINISH: begin
        if (!master_busy) state_fsm_s = S_IDLE;
        else state_fsm_s = S_FINISH;
      end
      default: state_fsm_s = S_IDLE;
    endcase
    state_s = wd_fire_s ? S_FINISH : state_fsm_s;
  end

  // Command fields for the next cycle, so cmd_* come straight from flops.
  always_comb begin
    rd_len_nx_s = accept_s ? rd_len : rd_len_r;
    if (accept_s) rd_cmd_cnt_s = 8'd0;
    else if ((state_r == S_RD_CMD) && cmd_hs_s) rd_cmd_cnt_s = rd_cmd_cnt_r + 8'd1;
    else rd_cmd_cnt_s = rd_cmd_cnt_r;
    cmd_valid_s = 1'b0;
    cmd_start_s = 1'b0;
    cmd_read_s  = 1'b0;
    cmd_wm_s    = 1'b0;
    cmd_stop_s  = 1'b0;
    case (state_s)
      S_WR_CMD: begin
        cmd_valid_s = 1'b1;
        cmd_start_s = 1'b1;
        cmd_wm_s    = 1'b1;
        cmd_stop_s  = (rd_len_nx_s == 8'd0);
      end
      S_RD_CMD: begin
        cmd_valid_s = 1'b1;
        cmd_read_s  = 1'b1;
        cmd_start_s = (rd_cmd_cnt_s == 8'd0);
        cmd_stop_s  = (rd_cmd_cnt_s == rd_len_nx_s - 8'd1);
      end
      default: begin
        cmd_valid_s = 1'b0;
      end
    endcase
  end

  // FIFO pointer/occupancy update; a watchdog abort discards everything queued.
  always_comb begin
    wptr_s = push_s ? wptr_r + AW'(1) : wptr_r;
    if (wd_fire_s) begin
      rptr_s  = wptr_s;
      count_s = '0;
    end else begin
      rptr_s  = pop_s ? rptr_r + AW'(1) : rptr_r;
      count_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end
  end

  // Sequencer state, latched request, counters, status and command flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      addr_r       <= 7'd0;
      wr_len_r     <= 8'd0;
      rd_len_r     <= 8'd0;
      tx_cnt_r     <= 8'd0;
      rd_cmd_cnt_r <= 8'd0;
      rx_cnt_r     <= 8'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      nack_r       <= 1'b0;
      wr_ready_r   <= 1'b0;
      cmd_valid_r  <= 1'b0;
      cmd_start_r  <= 1'b0;
      cmd_read_r   <= 1'b0;
      cmd_wm_r     <= 1'b0;
      cmd_stop_r   <= 1'b0;
      wptr_r       <= '0;
      rptr_r       <= '0;
      count_r      <= '0;
    end else begin
      state_r      <= state_s;
      rd_cmd_cnt_r <= rd_cmd_cnt_s;
      cmd_valid_r  <= cmd_valid_s;
      cmd_start_r  <= cmd_start_s;
      cmd_read_r   <= cmd_read_s;
      cmd_wm_r     <= cmd_wm_s;
      cmd_stop_r   <= cmd_stop_s;
      wptr_r       <= wptr_s;
      rptr_r       <= rptr_s;
      count_r      <= count_s;
      wr_ready_r   <= (count_s != DEPTH_C);
      done_r       <= (state_r == S_FINISH) && !master_busy;
      if (accept_s) begin
        addr_r   <= dev_addr;
        wr_len_r <= wr_len;
        rd_len_r <= rd_len;
        tx_cnt_r <= 8'd0;
        rx_cnt_r <= 8'd0;
        busy_r   <= 1'b1;
        nack_r   <= 1'b0;
      end else begin
        if (pop_s) tx_cnt_r <= tx_cnt_r + 8'd1;
        if ((state_r != S_IDLE) && rx_beat_s) rx_cnt_r <= rx_cnt_r + 8'd1;
        if ((state_r != S_IDLE) && missed_ack) nack_r <= 1'b1;
        if ((state_r == S_FINISH) && !master_busy) busy_r <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wptr_r] <= wr_data;
  end

`ifdef I2C_XFER_TIMEOUT_EN
  logic [15:0] wd_r;
  logic        timeout_r;

  assign wd_fire_s = busy_r && (state_r != S_IDLE) && (state_r != S_FINISH) && (wd_r == TO_LIMIT);
  assign timeout   = timeout_r;
  assign unused_s  = rx_tlast;

  // Watchdog: restarts on any progress, counts only while a transaction is open.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_r      <= 16'd0;
      timeout_r <= 1'b0;
    end else begin
      if (!busy_r || (state_s != state_r) || cmd_hs_s || pop_s || rx_beat_s) wd_r <= 16'd0;
      else wd_r <= wd_r + 16'd1;
      if (accept_s) timeout_r <= 1'b0;
      else if (wd_fire_s) timeout_r <= 1'b1;
    end
  end
`else
  assign wd_fire_s = 1'b0;
  assign timeout   = 1'b0;
  assign unused_s  = ^{rx_tlast, TO_LIMIT};
`endif

  assign busy               = busy_r;
  assign done               = done_r;
  assign nack               = nack_r;
  assign wr_ready           = wr_ready_r;
  assign cmd_address        = addr_r;
  assign cmd_valid          = cmd_valid_r;
  assign cmd_start          = cmd_start_r;
  assign cmd_read           = cmd_read_r;
  assign cmd_write          = 1'b0;
  assign cmd_write_multiple = cmd_wm_r;
  assign cmd_stop           = cmd_stop_r;
  assign tx_tdata           = tx_tvalid ? mem_r[rptr_r] : 8'd0;
  assign tx_tlast           = tx_tvalid && (tx_cnt_r == wr_len_r - 8'd1);
  assign rd_data            = rx_tdata;
  assign rd_valid           = rx_tvalid;
  assign rx_tready          = rd_ready;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed self-checking bench for i2c_xfer_seq. A small behavioural stand-in
// for i2c_master accepts commands, sinks tx beats and returns one rx byte per
// accepted read command.
module tb_i2c_xfer_seq;
  logic       clk = 1'b0;
  logic       rst, go, wr_valid, rd_ready, cmd_ready, tx_tready;
  logic       rx_tvalid, rx_tlast, master_busy, missed_ack;
  logic [6:0] dev_addr;
  logic [7:0] wr_len, rd_len, wr_data, rx_tdata;
  logic       busy, done, nack, timeout, wr_ready, rd_valid, rx_tready;
  logic [7:0] rd_data, tx_tdata;
  logic [6:0] cmd_address;
  logic       cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid;
  logic       tx_tvalid, tx_tlast;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [11:0] cmd_q[$];
  int          cmd_cyc_q[$];
  logic [8:0]  tx_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  rx_src[$];
  int          done_cnt;
  logic        nack_at_done, busy_at_done;

  always #5 clk = ~clk;

  i2c_xfer_seq #(.TX_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .go(go), .dev_addr(dev_addr), .wr_len(wr_len), .rd_len(rd_len),
    .busy(busy), .done(done), .nack(nack), .timeout(timeout),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
    .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
    .master_busy(master_busy), .missed_ack(missed_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic start_go(input logic [6:0] a, input logic [7:0] w, input logic [7:0] r);
    go       = 1'b1;
    dev_addr = a;
    wr_len   = w;
    rd_len   = r;
    step();
    go = 1'b0;
  endtask

  // Plays i2c_master until done is seen or the cycle budget runs out.
  task automatic run_xfer(input int max_cycles);
    int n_rd_cmd = 0;
    int rx_idx   = 0;
    bit fin      = 1'b0;
    cmd_q.delete(); cmd_cyc_q.delete(); tx_q.delete(); rd_q.delete();
    done_cnt = 0; nack_at_done = 1'b0; busy_at_done = 1'b1;
    for (int c = 0; c < max_cycles && !fin; c++) begin
      rx_tvalid = (rx_idx < n_rd_cmd) && (rx_idx < rx_src.size());
      rx_tdata  = rx_tvalid ? rx_src[rx_idx] : 8'h00;
      #1;
      if (cmd_valid && cmd_ready) begin
        cmd_q.push_back({cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop});
        cmd_cyc_q.push_back(c);
        if (cmd_read) n_rd_cmd++;
      end
      if (tx_tvalid && tx_tready) tx_q.push_back({tx_tlast, tx_tdata});
      if (rd_valid && rd_ready) rd_q.push_back(rd_data);
      if (rx_tvalid && rx_tready) rx_idx++;
      if (done) begin
        done_cnt++;
        nack_at_done = nack;
        busy_at_done = busy;
        fin = 1'b1;
      end
      step();
    end
    rx_tvalid = 1'b0;
    rx_tdata  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    chk_cnt++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); else pass_cnt++;
    chk_cnt++; if (tx_tvalid !== 1'b0) $display("FAIL reset_tx_tvalid: got %b want 0", tx_tvalid); else pass_cnt++;
    chk_cnt++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", wr_ready); else pass_cnt++;
    chk_cnt++; if ({nack, timeout} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {nack, timeout}); else pass_cnt++;
    rst = 1'b0;
    step();
    chk_cnt++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready_rise: got %b want 1", wr_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    start_go(7'h3C, 8'd2, 8'd0);
    chk_cnt++; if (cmd_valid !== 1'b1) $display("FAIL mid_cmd_valid_rise: got %b want 1", cmd_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else pass_cnt++;
    chk_cnt++; if ({cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop} !== {7'h3C, 5'b10011})
      $display("FAIL mid_cmd_fields: got %h want %h",
               {cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop}, {7'h3C, 5'b10011});
    else pass_cnt++;
    tx_tready = 1'b0;
    step();
    repeat (3) step();
    chk_cnt++; if (tx_tvalid !== 1'b0) $display("FAIL mid_underrun_tvalid: got %b want 0", tx_tvalid); else pass_cnt++;
    chk_cnt++; if (cmd_valid !== 1'b0) $display("FAIL mid_cmd_dropped: got %b want 0", cmd_valid); else pass_cnt++;
    push_byte(8'hEE);
    chk_cnt++; if ({tx_tvalid, tx_tdata, tx_tlast} !== {1'b1, 8'hEE, 1'b0})
      $display("FAIL mid_fwft: got %h want %h", {tx_tvalid, tx_tdata, tx_tlast}, {1'b1, 8'hEE, 1'b0});
    else pass_cnt++;
    rst = 1'b1;
    step();
    chk_cnt++; if ({busy, cmd_valid, tx_tvalid, wr_ready} !== 4'b0000)
      $display("FAIL mid_reset_outputs: got %b want 0000", {busy, cmd_valid, tx_tvalid, wr_ready});
    else pass_cnt++;
    rst = 1'b0;
    tx_tready = 1'b1;
    step();
    chk_cnt++; if (wr_ready !== 1'b1) $display("FAIL mid_wr_ready_rise: got %b want 1", wr_ready); else pass_cnt++;
  endtask

  task automatic test_write();
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    start_go(7'h50, 8'd3, 8'd0);
    run_xfer(60);
    chk_cnt++; if (cmd_q.size() !== 1) $display("FAIL wr_cmd_count: got %0d want 1", cmd_q.size()); else pass_cnt++;
    chk_cnt++; if (cmd_q[0] !== {7'h50, 5'b10011}) $display("FAIL wr_cmd0: got %h want %h", cmd_q[0], {7'h50, 5'b10011}); else pass_cnt++;
    chk_cnt++; if (tx_q.size() !== 3) $display("FAIL wr_tx_count: got %0d want 3", tx_q.size()); else pass_cnt++;
    chk_cnt++; if (tx_q[0] !== 9'h0A1) $display("FAIL wr_tx0: got %h want 0a1", tx_q[0]); else pass_cnt++;
    chk_cnt++; if (tx_q[1] !== 9'h0B2) $display("FAIL wr_tx1: got %h want 0b2", tx_q[1]); else pass_cnt++;
    chk_cnt++; if (tx_q[2] !== 9'h1C3) $display("FAIL wr_tx2_last: got %h want 1c3", tx_q[2]); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL wr_done: got %0d want 1", done_cnt); else pass_cnt++;
    chk_cnt++; if ({nack_at_done, busy_at_done} !== 2'b00)
      $display("FAIL wr_status_at_done: got %b want 00", {nack_at_done, busy_at_done}); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL wr_done_pulse: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_write_read();
    push_byte(8'h5A);
    rx_src = '{8'h11, 8'h22};
    start_go(7'h68, 8'd1, 8'd2);
    run_xfer(60);
    chk_cnt++; if (cmd_q.size() !== 3) $display("FAIL wrd_cmd_count: got %0d want 3", cmd_q.size()); else pass_cnt++;
    chk_cnt++; if (cmd_q[0] !== {7'h68, 5'b10010}) $display("FAIL wrd_cmd0: got %h want %h", cmd_q[0], {7'h68, 5'b10010}); else pass_cnt++;
    chk_cnt++; if (cmd_q[1] !== {7'h68, 5'b11000}) $display("FAIL wrd_cmd1: got %h want %h", cmd_q[1], {7'h68, 5'b11000}); else pass_cnt++;
    chk_cnt++; if (cmd_q[2] !== {7'h68, 5'b01001}) $display("FAIL wrd_cmd2: got %h want %h", cmd_q[2], {7'h68, 5'b01001}); else pass_cnt++;
    chk_cnt++; if (cmd_cyc_q[2] - cmd_cyc_q[1] !== 1)
      $display("FAIL wrd_rd_back_to_back: got gap %0d want 1", cmd_cyc_q[2] - cmd_cyc_q[1]); else pass_cnt++;
    chk_cnt++; if (tx_q[0] !== 9'h15A) $display("FAIL wrd_tx0: got %h want 15a", tx_q[0]); else pass_cnt++;
    chk_cnt++; if (rd_q.size() !== 2) $display("FAIL wrd_rd_count: got %0d want 2", rd_q.size()); else pass_cnt++;
    chk_cnt++; if ({rd_q[0], rd_q[1]} !== 16'h1122) $display("FAIL wrd_rd_bytes: got %h want 1122", {rd_q[0], rd_q[1]}); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL wrd_done: got %0d want 1", done_cnt); else pass_cnt++;
    rx_src.delete();
  endtask

  task automatic test_empty();
    master_busy = 1'b1;
    start_go(7'h10, 8'd0, 8'd0);
    chk_cnt++; if ({busy, cmd_valid} !== 2'b10) $display("FAIL empty_start: got %b want 10", {busy, cmd_valid}); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_cnt++; if ({done, cmd_valid} !== 2'b00) $display("FAIL empty_wait_%0d: got %b want 00", i, {done, cmd_valid}); else pass_cnt++;
    end
    master_busy = 1'b0;
    step();
    chk_cnt++; if ({done, busy} !== 2'b10) $display("FAIL empty_done: got %b want 10", {done, busy}); else pass_cnt++;
    go = 1'b1;
    step();
    go = 1'b0;
    chk_cnt++; if ({done, busy} !== 2'b00) $display("FAIL empty_go_during_done: got %b want 00", {done, busy}); else pass_cnt++;
  endtask

  task automatic test_nack();
    push_byte(8'h77); push_byte(8'h88);
    start_go(7'h22, 8'd2, 8'd0);
    tx_tready = 1'b0;
    step();
    chk_cnt++; if (nack !== 1'b0) $display("FAIL nack_before: got %b want 0", nack); else pass_cnt++;
    missed_ack = 1'b1;
    step();
    missed_ack = 1'b0;
    chk_cnt++; if (nack !== 1'b1) $display("FAIL nack_set: got %b want 1", nack); else pass_cnt++;
    tx_tready = 1'b1;
    run_xfer(50);
    chk_cnt++; if ({done_cnt == 1, nack_at_done} !== 2'b11)
      $display("FAIL nack_through_done: got done_cnt=%0d nack=%b want 1/1", done_cnt, nack_at_done); else pass_cnt++;
    chk_cnt++; if (tx_q.size() !== 2) $display("FAIL nack_tx_count: got %0d want 2", tx_q.size()); else pass_cnt++;
    start_go(7'h22, 8'd0, 8'd0);
    chk_cnt++; if ({nack, busy} !== 2'b01) $display("FAIL nack_cleared: got %b want 01", {nack, busy}); else pass_cnt++;
    run_xfer(10);
    chk_cnt++; if (done_cnt !== 1) $display("FAIL nack_next_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

`ifdef I2C_XFER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    start_go(7'h33, 8'd2, 8'd0);
    while (n < 400 && timeout !== 1'b1) begin
      step();
      n++;
    end
    chk_cnt++; if (timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", timeout); else pass_cnt++;
    chk_cnt++; if (n < 95 || n > 115) $display("FAIL to_latency: got %0d cycles want about 100", n); else pass_cnt++;
    chk_cnt++; if ({cmd_valid, tx_tvalid} !== 2'b00) $display("FAIL to_dropped: got %b want 00", {cmd_valid, tx_tvalid}); else pass_cnt++;
    run_xfer(20);
    chk_cnt++; if (done_cnt !== 1) $display("FAIL to_done: got %0d want 1", done_cnt); else pass_cnt++;
    start_go(7'h33, 8'd0, 8'd0);
    chk_cnt++; if (timeout !== 1'b0) $display("FAIL to_cleared: got %b want 0", timeout); else pass_cnt++;
    run_xfer(10);
  endtask
`endif

  initial begin
    rst = 1'b1; go = 1'b0; dev_addr = 7'd0; wr_len = 8'd0; rd_len = 8'd0;
    wr_data = 8'd0; wr_valid = 1'b0; rd_ready = 1'b1; cmd_ready = 1'b1; tx_tready = 1'b1;
    rx_tdata = 8'd0; rx_tvalid = 1'b0; rx_tlast = 1'b0; master_busy = 1'b0; missed_ack = 1'b0;
    test_reset();
    test_reset_mid();
    test_write();
    test_write_read();
    test_empty();
    test_nack();
`ifdef I2C_XFER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
